rle_blob_tracker: RTL and testbench

- Sits directly downstream of the per-line RLE encoder in the vision pipeline.
- Consumes one filtered run per line: leading black length `stream1` and white run length `stream2`, sampled while `line_end` is high.
- Links runs across consecutive lines into vertical blobs and keeps the tallest blob in the frame.
- At each frame boundary, emits that blob's bounding box, centre and area over a valid/ready handshake, for the rover navigation controller.

---
 rtl/rle_blob_tracker.sv | 256 +++++++++++++++++++++++++
 tb/tb_rle_blob_tracker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_blob_tracker.sv
// rtl/rle_blob_tracker.sv - links per-line RLE runs into vertical blobs, reports the tallest per frame
// A frame result is latched on frame_start and held on a valid/ready port until accepted.
module rle_blob_tracker #(
    parameter int IMAGE_W   = 638,
    parameter int IMAGE_H   = 480,
    parameter int GAP_TOL   = 2,
    parameter int MIN_LINES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        frame_start,
    input  logic        line_end,
    input  logic [9:0]  stream1,
    input  logic [9:0]  stream2,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        found,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [8:0]  y_min,
    output logic [8:0]  y_max,
    output logic [9:0]  x_centre,
    output logic [8:0]  y_centre,
    output logic [18:0] area,
    output logic        dropped
);

    localparam logic [10:0] XMAX     = 11'(IMAGE_W - 1);
    localparam logic [8:0]  HLIM     = 9'(IMAGE_H);
    localparam logic [3:0]  GTOL     = 4'(GAP_TOL);
    localparam logic [8:0]  MINL     = 9'(MIN_LINES);
    localparam logic [19:0] AREA_SAT = 20'h7FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLOB,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [9:0]  x_min;
        logic [9:0]  x_max;
        logic [8:0]  y_min;
        logic [8:0]  y_max;
        logic [18:0] area;
        logic [8:0]  lines;
    } blob_t;

    state_t      r_state, w_state_n;
    blob_t       r_cur, w_cur_n;
    blob_t       r_best, w_best_n;
    blob_t       w_final;
    logic [9:0]  r_last_rs, w_last_rs_n;
    logic [9:0]  r_last_re, w_last_re_n;
    logic [3:0]  r_gap, w_gap_n;
    logic [8:0]  r_line_idx, w_line_idx_n;

    logic        r_out_valid;
    logic        r_found;
    logic [9:0]  r_x_min, r_x_max, r_x_centre;
    logic [8:0]  r_y_min, r_y_max, r_y_centre;
    logic [18:0] r_area;
    logic        r_dropped;

    logic [10:0] w_sum;
    logic [9:0]  w_re;
    logic [9:0]  w_diff;
    logic [18:0] w_len;
    logic [19:0] w_area_sum;
    logic [18:0] w_area_ext;
    logic        w_in_frame, w_hit, w_miss, w_overlap, w_cur_wins;
    logic [3:0]  w_gap_inc;
    blob_t       w_open, w_ext;
    logic        w_found;

    // Run end is formed at 11 bits so a run spilling past the right edge clips instead of wrapping.
    assign w_sum      = {1'b0, stream1} + {1'b0, stream2} - 11'd1;
    assign w_re       = (w_sum > XMAX) ? XMAX[9:0] : w_sum[9:0];
    assign w_diff     = w_re - stream1;
    assign w_len      = (w_re >= stream1) ? ({9'd0, w_diff} + 19'd1) : 19'd0;
    assign w_area_sum = {1'b0, r_cur.area} + {1'b0, w_len};
    assign w_area_ext = (w_area_sum > AREA_SAT) ? AREA_SAT[18:0] : w_area_sum[18:0];

    assign w_in_frame = (r_line_idx < HLIM);
    assign w_hit      = line_end && w_in_frame && (stream2 != 10'd0);
    assign w_miss     = line_end && w_in_frame && (stream2 == 10'd0);
    assign w_overlap  = (stream1 <= r_last_re) && (w_re >= r_last_rs);
    assign w_cur_wins = (r_cur.lines > r_best.lines);
    assign w_gap_inc  = r_gap + 4'd1;

    always_comb begin
        w_open       = '0;
        w_open.x_min = stream1;
        w_open.x_max = w_re;
        w_open.y_min = r_line_idx;
        w_open.y_max = r_line_idx;
        w_open.area  = w_len;
        w_open.lines = 9'd1;

        w_ext        = r_cur;
        w_ext.x_min  = (stream1 < r_cur.x_min) ? stream1 : r_cur.x_min;
        w_ext.x_max  = (w_re > r_cur.x_max) ? w_re : r_cur.x_max;
        w_ext.y_max  = r_line_idx;
        w_ext.area   = w_area_ext;
        w_ext.lines  = r_cur.lines + 9'd1;
    end

    always_comb begin
        w_state_n    = r_state;
        w_cur_n      = r_cur;
        w_best_n     = r_best;
        w_last_rs_n  = r_last_rs;
        w_last_re_n  = r_last_re;
        w_gap_n      = r_gap;
        w_line_idx_n = r_line_idx;
        w_final      = '0;

        if (line_end && w_in_frame) begin
            w_line_idx_n = r_line_idx + 9'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_cur_n     = w_open;
                    w_last_rs_n = stream1;
                    w_last_re_n = w_re;
                    w_gap_n     = 4'd0;
                    w_state_n   = ST_BLOB;
                end
            end
            ST_BLOB, ST_GAP: begin
                if (w_hit && w_overlap) begin
                    w_cur_n     = w_ext;
                    w_last_rs_n = stream1;
                    w_last_re_n = w_re;
                    w_gap_n     = 4'd0;
                    w_state_n   = ST_BLOB;
                end else if (w_hit) begin
                    if (w_cur_wins) begin
                        w_best_n = r_cur;
                    end
                    w_cur_n     = w_open;
                    w_last_rs_n = stream1;
                    w_last_re_n = w_re;
                    w_gap_n     = 4'd0;
                    w_state_n   = ST_BLOB;
                end else if (w_miss) begin
                    if (r_state == ST_BLOB) begin
                        w_gap_n   = 4'd1;
                        w_state_n = ST_GAP;
                    end else begin
                        w_gap_n = w_gap_inc;
                        if (w_gap_inc > GTOL) begin
                            if (w_cur_wins) begin
                                w_best_n = r_cur;
                            end
                            w_state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // The frame's own last line is folded in above before the open blob is closed here.
        w_final = w_best_n;
        if ((w_state_n != ST_IDLE) && (w_cur_n.lines > w_best_n.lines)) begin
            w_final = w_cur_n;
        end

        if (frame_start) begin
            w_state_n    = ST_IDLE;
            w_cur_n      = '0;
            w_best_n     = '0;
            w_last_rs_n  = 10'd0;
            w_last_re_n  = 10'd0;
            w_gap_n      = 4'd0;
            w_line_idx_n = 9'd0;
        end
    end

    assign w_found = (w_final.lines >= MINL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_best     <= '0;
            r_last_rs  <= 10'd0;
            r_last_re  <= 10'd0;
            r_gap      <= 4'd0;
            r_line_idx <= 9'd0;
        end else begin
            r_state    <= w_state_n;
            r_cur      <= w_cur_n;
            r_best     <= w_best_n;
            r_last_rs  <= w_last_rs_n;
            r_last_re  <= w_last_re_n;
            r_gap      <= w_gap_n;
            r_line_idx <= w_line_idx_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_found     <= 1'b0;
            r_x_min     <= 10'd0;
            r_x_max     <= 10'd0;
            r_y_min     <= 9'd0;
            r_y_max     <= 9'd0;
            r_x_centre  <= 10'd0;
            r_y_centre  <= 9'd0;
            r_area      <= 19'd0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped <= frame_start && r_out_valid && !out_ready;
            if (frame_start) begin
                r_out_valid <= 1'b1;
                r_found     <= w_found;
                if (w_found) begin
                    r_x_min    <= w_final.x_min;
                    r_x_max    <= w_final.x_max;
                    r_y_min    <= w_final.y_min;
                    r_y_max    <= w_final.y_max;
                    r_x_centre <= 10'(({1'b0, w_final.x_min} + {1'b0, w_final.x_max}) >> 1);
                    r_y_centre <= 9'(({1'b0, w_final.y_min} + {1'b0, w_final.y_max}) >> 1);
                    r_area     <= w_final.area;
                end else begin
                    r_x_min    <= 10'd0;
                    r_x_max    <= 10'd0;
                    r_y_min    <= 9'd0;
                    r_y_max    <= 9'd0;
                    r_x_centre <= 10'd0;
                    r_y_centre <= 9'd0;
                    r_area     <= 19'd0;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign found     = r_found;
    assign x_min     = r_x_min;
    assign x_max     = r_x_max;
    assign y_min     = r_y_min;
    assign y_max     = r_y_max;
    assign x_centre  = r_x_centre;
    assign y_centre  = r_y_centre;
    assign area      = r_area;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_rle_blob_tracker.sv
// tb/tb_rle_blob_tracker.sv - self-checking bench for rle_blob_tracker
module tb_rle_blob_tracker;

    localparam int W   = 638;
    localparam int H   = 480;
    localparam int GT  = 2;
    localparam int MNL = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        frame_start, line_end, out_ready;
    logic [9:0]  stream1, stream2;
    logic        out_valid, found, dropped;
    logic [9:0]  x_min, x_max, x_centre;
    logic [8:0]  y_min, y_max, y_centre;
    logic [18:0] area;

    rle_blob_tracker dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .line_end(line_end),
        .stream1(stream1), .stream2(stream2), .out_ready(out_ready),
        .out_valid(out_valid), .found(found), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max), .x_centre(x_centre), .y_centre(y_centre),
        .area(area), .dropped(dropped)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int found, xmin, xmax, ymin, ymax, xc, yc, area;
    } res_t;

    typedef struct {
        int y0, na, s1a, s2a, gap, nb, s1b, s2b;
        res_t exp;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    int   ln_s1[0:599];
    int   ln_s2[0:599];
    vec_t vecs[8];

    function automatic res_t mk_res(input int f, input int x0, input int x1, input int y0,
                                    input int y1, input int xc, input int yc, input int a);
        res_t r;
        r.found = f; r.xmin = x0; r.xmax = x1; r.ymin = y0; r.ymax = y1;
        r.xc = xc; r.yc = yc; r.area = a;
        return r;
    endfunction

    function automatic vec_t mk_vec(input int y0, input int na, input int s1a, input int s2a,
                                    input int gap, input int nb, input int s1b, input int s2b,
                                    input res_t e);
        vec_t v;
        v.y0 = y0; v.na = na; v.s1a = s1a; v.s2a = s2a; v.gap = gap;
        v.nb = nb; v.s1b = s1b; v.s2b = s2b; v.exp = e;
        return v;
    endfunction

    // Blob = hits chained by x-overlap with the previous hit, at most GT misses between them.
    function automatic res_t model(input int n);
        res_t r;
        int bl, bx0, bx1, by0, by1, ba;
        int open, cl, cx0, cx1, cy0, cy1, ca;
        int lrs, lre, miss, rs, re, len;
        bit hit, ext, do_close, do_open;
        bl = 0; bx0 = 0; bx1 = 0; by0 = 0; by1 = 0; ba = 0;
        open = 0; cl = 0; cx0 = 0; cx1 = 0; cy0 = 0; cy1 = 0; ca = 0;
        lrs = 0; lre = 0; miss = 0;
        for (int i = 0; i < n && i < H; i++) begin
            hit = (ln_s2[i] != 0);
            ext = 0; do_close = 0; do_open = 0;
            rs  = ln_s1[i];
            re  = rs + ln_s2[i] - 1;
            if (re > W - 1) re = W - 1;
            len = (re >= rs) ? re - rs + 1 : 0;
            if (hit) begin
                if (open != 0 && rs <= lre && re >= lrs) ext = 1;
                else begin do_close = (open != 0); do_open = 1; end
            end else if (open != 0) begin
                miss++;
                if (miss > GT) begin do_close = 1; open = 0; end
            end
            if (do_close && cl > bl) begin
                bl = cl; bx0 = cx0; bx1 = cx1; by0 = cy0; by1 = cy1; ba = ca;
            end
            if (do_open) begin
                open = 1; cl = 1; cx0 = rs; cx1 = re; cy0 = i; cy1 = i; ca = len;
            end
            if (ext) begin
                if (rs < cx0) cx0 = rs;
                if (re > cx1) cx1 = re;
                cy1 = i; cl++; ca += len;
                if (ca > 524287) ca = 524287;
            end
            if (hit) begin lrs = rs; lre = re; miss = 0; end
        end
        if (open != 0 && cl > bl) begin
            bl = cl; bx0 = cx0; bx1 = cx1; by0 = cy0; by1 = cy1; ba = ca;
        end
        if (bl >= MNL) r = mk_res(1, bx0, bx1, by0, by1, (bx0 + bx1) / 2, (by0 + by1) / 2, ba);
        else           r = mk_res(0, 0, 0, 0, 0, 0, 0, 0);
        return r;
    endfunction

    function automatic int build(input vec_t v);
        int n;
        n = 0;
        for (int i = 0; i < v.y0; i++)  begin ln_s1[n] = 0;     ln_s2[n] = 0;     n++; end
        for (int i = 0; i < v.na; i++)  begin ln_s1[n] = v.s1a; ln_s2[n] = v.s2a; n++; end
        for (int i = 0; i < v.gap; i++) begin ln_s1[n] = 0;     ln_s2[n] = 0;     n++; end
        for (int i = 0; i < v.nb; i++)  begin ln_s1[n] = v.s1b; ln_s2[n] = v.s2b; n++; end
        return n;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".out_valid"}, int'(out_valid), 1);
        chk({tag, ".found"},     int'(found),     e.found);
        chk({tag, ".x_min"},     int'(x_min),     e.xmin);
        chk({tag, ".x_max"},     int'(x_max),     e.xmax);
        chk({tag, ".y_min"},     int'(y_min),     e.ymin);
        chk({tag, ".y_max"},     int'(y_max),     e.ymax);
        chk({tag, ".x_centre"},  int'(x_centre),  e.xc);
        chk({tag, ".y_centre"},  int'(y_centre),  e.yc);
        chk({tag, ".area"},      int'(area),      e.area);
    endtask

    task automatic send_lines(input int from, input int to);
        for (int i = from; i < to; i++) begin
            line_end = 1'b1;
            stream1  = 10'(ln_s1[i]);
            stream2  = 10'(ln_s2[i]);
            tick();
        end
        line_end = 1'b0;
        stream1  = '0;
        stream2  = '0;
    endtask

    // With coincide set, line n-1 is presented on the frame_start cycle itself.
    task automatic run_frame(input int n, input bit coincide);
        send_lines(0, (coincide && n > 0) ? n - 1 : n);
        frame_start = 1'b1;
        if (coincide && n > 0) begin
            line_end = 1'b1;
            stream1  = 10'(ln_s1[n-1]);
            stream2  = 10'(ln_s2[n-1]);
        end
        tick();
        frame_start = 1'b0;
        line_end    = 1'b0;
        stream1     = '0;
        stream2     = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        res_t e, zero;
        zero = mk_res(0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0] = mk_vec(100, 10, 200, 40, 0, 0, 0, 0,    mk_res(1, 200, 239, 100, 109, 219, 104, 400));
        vecs[1] = mk_vec(10, 4, 50, 10, 2, 4, 50, 10,      mk_res(1, 50, 59, 10, 19, 54, 14, 80));
        vecs[2] = mk_vec(10, 4, 50, 10, 3, 4, 50, 10,      mk_res(1, 50, 59, 10, 13, 54, 11, 40));
        vecs[3] = mk_vec(0, 5, 10, 10, 0, 7, 300, 10,      mk_res(1, 300, 309, 5, 11, 304, 8, 70));
        vecs[4] = mk_vec(0, 3, 630, 20, 0, 0, 0, 0,        zero);
        vecs[5] = mk_vec(0, 4, 630, 20, 0, 0, 0, 0,        mk_res(1, 630, 637, 0, 3, 633, 1, 32));
        vecs[6] = mk_vec(20, 4, 100, 50, 0, 5, 140, 30,    mk_res(1, 100, 169, 20, 28, 134, 24, 350));
        vecs[7] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0,           zero);

        RST = 1'b1; frame_start = 1'b0; line_end = 1'b0; out_ready = 1'b0;
        stream1 = '0; stream2 = '0;
        tick(); tick();
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.found",     int'(found),     0);
        chk("reset.area",      int'(area),      0);
        chk("reset.dropped",   int'(dropped),   0);
        RST = 1'b0;

        // Pending result and a half-built frame are both wiped by reset.
        n = build(vecs[0]);
        run_frame(n, 0);
        chk("pre_reset.out_valid", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin ln_s1[i] = 50; ln_s2[i] = 5; end
        send_lines(0, 3);
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        chk("mid_reset.out_valid", int'(out_valid), 0);
        run_frame(0, 0);
        chk_res("after_reset", zero);
        chk("after_reset.dropped", int'(dropped), 0);

        out_ready = 1'b1; tick();
        chk("accept.out_valid", int'(out_valid), 0);
        out_ready = 1'b0;

        n = build(vecs[0]);
        run_frame(n, 0);
        chk_res("hs_first", vecs[0].exp);
        chk("hs_first.dropped", int'(dropped), 0);
        n = build(vecs[3]);
        send_lines(0, n);
        chk("hs_hold.out_valid", int'(out_valid), 1);
        chk("hs_hold.area",      int'(area),      400);
        chk("hs_hold.dropped",   int'(dropped),   0);
        run_frame(0, 0);
        chk("hs_over.dropped", int'(dropped), 1);
        chk_res("hs_over", vecs[3].exp);
        tick();
        chk("hs_pulse_end.dropped",   int'(dropped),   0);
        chk("hs_pulse_end.out_valid", int'(out_valid), 1);

        out_ready = 1'b1;
        run_frame(0, 0);
        chk("hs_same.dropped",   int'(dropped),   0);
        chk("hs_same.out_valid", int'(out_valid), 1);
        chk("hs_same.found",     int'(found),     0);
        tick();
        chk("hs_drain.out_valid", int'(out_valid), 0);

        for (int v = 0; v < 8; v++) begin
            n = build(vecs[v]);
            run_frame(n, 0);
            chk_res($sformatf("vec%0d", v), vecs[v].exp);
        end

        for (int i = 0; i < 476; i++) begin ln_s1[i] = 0; ln_s2[i] = 0; end
        for (int i = 476; i < 480; i++) begin ln_s1[i] = 100; ln_s2[i] = 10; end
        run_frame(480, 1);
        chk_res("last_line", mk_res(1, 100, 109, 476, 479, 104, 477, 40));

        for (int f = 0; f < 24; f++) begin
            bit co;
            n  = (f == 23) ? 490 : $urandom_range(5, 60);
            co = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                ln_s2[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
                ln_s1[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 637)
                                                       : $urandom_range(100, 140);
            end
            e = model(n);
            run_frame(n, co);
            chk_res($sformatf("rand%0d", f), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
